// File: rtl/photonic_allocator_pkg.sv
// Shared defaults and types for the photonic crossbar slot allocator.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package photonic_allocator_pkg;

    // Default crossbar geometry.
    localparam int PA_PORTS     = 4;
    localparam int PA_BUF_DEPTH = 8;
    localparam int PA_DW        = $clog2(PA_PORTS);

    // One crossbar configuration row (one bit per source).
    typedef logic [PA_PORTS-1:0] cfg_row_t;
    // Port number / destination field.
    typedef logic [PA_DW-1:0]    port_idx_t;

endpackage

// File: rtl/photonic_allocator_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after ptr.
// Latency: combinational, no state (pointer is owned by the caller).
// Backpressure: none; gnt_vld low means nothing requested.
//
// Ports: req (request vector), ptr (highest-priority index),
//        gnt (one-hot grant), gnt_vld (some request granted).
module photonic_allocator_rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic          gnt_vld
);

    logic [IW-1:0] idx;

    // N is a power of two, so the IW-bit add wraps the scan around naturally.
    always_comb begin
        gnt     = '0;
        gnt_vld = 1'b0;
        idx     = '0;
        for (int k = 0; k < N; k++) begin
            idx = ptr + IW'(k);
            if (!gnt_vld && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_vld  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/photonic_allocator.sv
// Per-slot scheduler for the speculative photonic crossbar with per-port OEO buffers.
// Latency: inputs sampled at edge N, all outputs registered and valid after edge N.
// Backpressure: none; contention losers go to their own OEO buffer, or are dropped when it is full.
//
// Ports: clk, rst_n (async active-low); req_valid/req_dest (live packets);
//        buf_dest (head of each OEO buffer); switch_config / switch_config_buf
//        (crossbar rows, one per output); grant, buf_push, buf_pop, drop
//        (per-input pulses); buf_count (tracked occupancy); drop_cnt (saturating).
module photonic_allocator
    import photonic_allocator_pkg::*;
#(
    parameter int PORTS     = PA_PORTS,
    parameter int BUF_DEPTH = PA_BUF_DEPTH,
    parameter int DW        = $clog2(PORTS),
    localparam int CW       = $clog2(BUF_DEPTH + 1),
    localparam int AW       = $clog2(PORTS + 1)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [PORTS-1:0]             req_valid,
    input  logic [PORTS-1:0][DW-1:0]     req_dest,
    input  logic [PORTS-1:0][DW-1:0]     buf_dest,
    output logic [PORTS-1:0][PORTS-1:0]  switch_config,
    output logic [PORTS-1:0][PORTS-1:0]  switch_config_buf,
    output logic [PORTS-1:0]             grant,
    output logic [PORTS-1:0]             buf_push,
    output logic [PORTS-1:0]             buf_pop,
    output logic [PORTS-1:0]             drop,
    output logic [PORTS-1:0][CW-1:0]     buf_count,
    output logic [31:0]                  drop_cnt
);

    logic [PORTS-1:0][DW-1:0]    bptr_q, bptr_d;
    logic [PORTS-1:0][DW-1:0]    iptr_q, iptr_d;
    logic [PORTS-1:0][PORTS-1:0] buf_req, buf_gnt;
    logic [PORTS-1:0][PORTS-1:0] live_req, live_gnt;
    logic [PORTS-1:0]            buf_won, live_won;
    logic [PORTS-1:0]            pop_d, grant_d, push_d, drop_d;
    logic [PORTS-1:0][PORTS-1:0] cfg_d;
    logic [PORTS-1:0][CW-1:0]    count_d;
    logic [AW-1:0]               drop_add;
    logic [32:0]                 drop_sum;
    logic [31:0]                 drop_cnt_d;

    // Buffer stage requests: a buffer bids only when it holds a packet.
    // A self-addressed head is illegal and simply never bids.
    always_comb begin
        buf_req = '0;
        for (int j = 0; j < PORTS; j++) begin
            for (int i = 0; i < PORTS; i++) begin
                buf_req[j][i] = (buf_count[i] != '0) && (buf_dest[i] == DW'(j))
                              && (buf_dest[i] != DW'(i));
            end
        end
    end

    // Live stage requests: an output already claimed by a buffer is closed to live traffic.
    always_comb begin
        live_req = '0;
        for (int j = 0; j < PORTS; j++) begin
            for (int i = 0; i < PORTS; i++) begin
                live_req[j][i] = req_valid[i] && (req_dest[i] == DW'(j))
                               && (req_dest[i] != DW'(i)) && !buf_won[j];
            end
        end
    end

    for (genvar j = 0; j < PORTS; j++) begin : g_arb
        photonic_allocator_rr_arbiter #(.N(PORTS), .IW(DW)) u_buf_arb (
            .req     (buf_req[j]),
            .ptr     (bptr_q[j]),
            .gnt     (buf_gnt[j]),
            .gnt_vld (buf_won[j])
        );
        photonic_allocator_rr_arbiter #(.N(PORTS), .IW(DW)) u_live_arb (
            .req     (live_req[j]),
            .ptr     (iptr_q[j]),
            .gnt     (live_gnt[j]),
            .gnt_vld (live_won[j])
        );
    end

    // Merge per-output grants into per-input pulses, then divert or drop losers.
    // "Full" is judged after this slot's pop, so a full buffer that is also
    // sending its head can still absorb a loser.
    always_comb begin
        pop_d   = '0;
        grant_d = '0;
        push_d  = '0;
        drop_d  = '0;
        for (int j = 0; j < PORTS; j++) begin
            pop_d   = pop_d | buf_gnt[j];
            grant_d = grant_d | live_gnt[j];
        end
        for (int i = 0; i < PORTS; i++) begin
            if (req_valid[i] && (req_dest[i] != DW'(i)) && !grant_d[i]) begin
                if ((buf_count[i] == CW'(BUF_DEPTH)) && !pop_d[i]) begin
                    drop_d[i] = 1'b1;
                end else begin
                    push_d[i] = 1'b1;
                end
            end
        end
    end

    // Configuration rows, occupancy, pointers and drop total for the next slot.
    always_comb begin
        cfg_d    = '0;
        count_d  = buf_count;
        bptr_d   = bptr_q;
        iptr_d   = iptr_q;
        drop_add = '0;
        for (int j = 0; j < PORTS; j++) begin
            cfg_d[j]    = live_gnt[j];
            cfg_d[j][j] = push_d[j];   // diagonal bit routes input j into its own buffer
            // Pointer moves just past the winner; DW-bit truncation gives the mod PORTS wrap.
            for (int i = 0; i < PORTS; i++) begin
                if (buf_gnt[j][i]) begin
                    bptr_d[j] = DW'(i + 1);
                end
                if (live_gnt[j][i]) begin
                    iptr_d[j] = DW'(i + 1);
                end
            end
            case ({push_d[j], pop_d[j]})
                2'b10:   count_d[j] = buf_count[j] + CW'(1);
                2'b01:   count_d[j] = buf_count[j] - CW'(1);
                default: count_d[j] = buf_count[j];
            endcase
            drop_add = drop_add + AW'(drop_d[j]);
        end
        drop_sum   = {1'b0, drop_cnt} + 33'(drop_add);
        drop_cnt_d = drop_sum[32] ? '1 : drop_sum[31:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            switch_config     <= '0;
            switch_config_buf <= '0;
            grant             <= '0;
            buf_push          <= '0;
            buf_pop           <= '0;
            drop              <= '0;
            buf_count         <= '0;
            drop_cnt          <= '0;
            bptr_q            <= '0;
            iptr_q            <= '0;
        end else begin
            switch_config     <= cfg_d;
            switch_config_buf <= buf_gnt;
            grant             <= grant_d;
            buf_push          <= push_d;
            buf_pop           <= pop_d;
            drop              <= drop_d;
            buf_count         <= count_d;
            drop_cnt          <= drop_cnt_d;
            bptr_q            <= bptr_d;
            iptr_q            <= iptr_d;
        end
    end

`ifndef SYNTHESIS
    // Self-addressed traffic is ignored by the logic above; flag it in simulation.
    for (genvar g = 0; g < PORTS; g++) begin : g_chk
        a_req_dest: assert property (@(posedge clk) disable iff (!rst_n)
            req_valid[g] |-> (req_dest[g] != DW'(g)));
        a_buf_dest: assert property (@(posedge clk) disable iff (!rst_n)
            (buf_count[g] != '0) |-> (buf_dest[g] != DW'(g)));
        a_count_rng: assert property (@(posedge clk) disable iff (!rst_n)
            buf_count[g] <= CW'(BUF_DEPTH));
    end
`endif

endmodule

// File: tb/tb_photonic_allocator.sv
// Randomised bench for photonic_allocator against a queue-based slot model.
// Latency: checks each slot's outputs one cycle after the inputs are applied.
// Backpressure: n/a; the bench plays the sources and the OEO buffers.
module tb_photonic_allocator;

    localparam int P  = 4;
    localparam int D  = 8;
    localparam int DW = 2;
    localparam int CW = 4;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [P-1:0]         req_valid;
    logic [P-1:0][DW-1:0] req_dest;
    logic [P-1:0][DW-1:0] buf_dest;
    logic [P-1:0][P-1:0]  switch_config;
    logic [P-1:0][P-1:0]  switch_config_buf;
    logic [P-1:0]         grant, buf_push, buf_pop, drop;
    logic [P-1:0][CW-1:0] buf_count;
    logic [31:0]          drop_cnt;

    always #5 clk = ~clk;

    photonic_allocator #(.PORTS(P), .BUF_DEPTH(D), .DW(DW)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .req_valid         (req_valid),
        .req_dest          (req_dest),
        .buf_dest          (buf_dest),
        .switch_config     (switch_config),
        .switch_config_buf (switch_config_buf),
        .grant             (grant),
        .buf_push          (buf_push),
        .buf_pop           (buf_pop),
        .drop              (drop),
        .buf_count         (buf_count),
        .drop_cnt          (drop_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: each OEO buffer is a queue of real packet destinations,
    // arbitration pointers are plain integers.
    int                  q[P][$];
    int                  bptr[P];
    int                  iptr[P];
    logic [P-1:0][P-1:0] e_cfg, e_cfgb;
    logic [P-1:0]        e_grant, e_push, e_pop, e_drop;
    longint              e_dcnt;
    bit                  saw_drop;
    logic [P-1:0][DW-1:0] rd_v;

    task automatic model_reset();
        for (int i = 0; i < P; i++) begin
            q[i].delete();
            bptr[i] = 0;
            iptr[i] = 0;
        end
        e_dcnt = 0;
    endtask

    function automatic logic [DW-1:0] rand_dest(input int i);
        int d;
        d = $urandom_range(0, P - 2);
        if (d >= i) d++;
        return DW'(d);
    endfunction

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check_val("rst_cfg",   64'(switch_config), 64'd0);
        check_val("rst_cfgb",  64'(switch_config_buf), 64'd0);
        check_val("rst_count", 64'(buf_count), 64'd0);
        check_val("rst_dcnt",  64'(drop_cnt), 64'd0);
        rst_n = 1'b1;
    endtask

    // Apply one slot of live requests, predict the result, check it after the edge.
    task automatic run_slot(input logic [P-1:0] rv, input logic [P-1:0][DW-1:0] rd);
        logic [P-1:0][CW-1:0] e_bc;
        bit won;
        int b, n;
        req_valid = rv;
        req_dest  = rd;
        for (int i = 0; i < P; i++)
            buf_dest[i] = (q[i].size() > 0) ? DW'(q[i][0]) : DW'((i + 1) % P);
        e_cfg = '0; e_cfgb = '0; e_grant = '0; e_push = '0; e_pop = '0; e_drop = '0;
        for (int j = 0; j < P; j++) begin
            won = 0;
            for (int k = 0; k < P; k++) begin
                b = (bptr[j] + k) % P;
                if (!won && q[b].size() > 0 && q[b][0] == j) begin
                    won = 1; e_cfgb[j][b] = 1'b1; e_pop[b] = 1'b1; bptr[j] = (b + 1) % P;
                end
            end
            for (int k = 0; k < P; k++) begin
                b = (iptr[j] + k) % P;
                if (!won && rv[b] && int'(rd[b]) == j) begin
                    won = 1; e_cfg[j][b] = 1'b1; e_grant[b] = 1'b1; iptr[j] = (b + 1) % P;
                end
            end
        end
        n = 0;
        for (int i = 0; i < P; i++) begin
            if (rv[i] && !e_grant[i]) begin
                if (q[i].size() - int'(e_pop[i]) < D) begin
                    e_push[i] = 1'b1; e_cfg[i][i] = 1'b1;
                end else begin
                    e_drop[i] = 1'b1; n++; saw_drop = 1;
                end
            end
        end
        for (int i = 0; i < P; i++) begin
            if (e_pop[i]) void'(q[i].pop_front());
            if (e_push[i]) q[i].push_back(int'(rd[i]));
            e_bc[i] = CW'(q[i].size());
        end
        e_dcnt = (e_dcnt + n > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : e_dcnt + n;
        @(posedge clk);
        @(negedge clk);
        check_val("switch_config",     64'(switch_config), 64'(e_cfg));
        check_val("switch_config_buf", 64'(switch_config_buf), 64'(e_cfgb));
        check_val("grant",             64'(grant), 64'(e_grant));
        check_val("buf_push",          64'(buf_push), 64'(e_push));
        check_val("buf_pop",           64'(buf_pop), 64'(e_pop));
        check_val("drop",              64'(drop), 64'(e_drop));
        check_val("buf_count",         64'(buf_count), 64'(e_bc));
        check_val("drop_cnt",          64'(drop_cnt), 64'(e_dcnt));
    endtask

    task automatic random_slots(input int cnt, input bit heavy);
        logic [P-1:0]         rv;
        logic [P-1:0][DW-1:0] rd;
        for (int s = 0; s < cnt; s++) begin
            rv = heavy ? 4'hF : P'($urandom_range(0, 15));
            for (int i = 0; i < P; i++) rd[i] = rand_dest(i);
            run_slot(rv, rd);
        end
    endtask

    initial begin
        req_valid = '0;
        req_dest  = '0;
        buf_dest  = {2'd0, 2'd3, 2'd2, 2'd1};
        saw_drop  = 0;
        do_reset();

        // Idle slot after reset.
        run_slot(4'b0000, '0);

        // Single packet 0 -> 2.
        rd_v = '0; rd_v[0] = 2'd2;
        run_slot(4'b0001, rd_v);
        check_val("single_row2",  64'(switch_config[2]), 64'b0001);
        check_val("single_grant", 64'(grant), 64'b0001);
        check_val("single_push",  64'(buf_push), 64'd0);

        // Contention: inputs 0,1,3 all to output 2 from fresh pointers.
        do_reset();
        rd_v = '0; rd_v[0] = 2'd2; rd_v[1] = 2'd2; rd_v[3] = 2'd2;
        run_slot(4'b1011, rd_v);
        check_val("cont_grant", 64'(grant), 64'b0001);
        check_val("cont_diag1", 64'(switch_config[1][1]), 64'd1);
        check_val("cont_diag3", 64'(switch_config[3][3]), 64'd1);
        check_val("cont_push",  64'(buf_push), 64'b1010);
        check_val("cont_cnt1",  64'(buf_count[1]), 64'd1);
        check_val("cont_cnt3",  64'(buf_count[3]), 64'd1);

        // Buffer 1 (head to 2) beats live input 0 -> 2; input 0 diverted.
        rd_v = '0; rd_v[0] = 2'd2;
        run_slot(4'b0001, rd_v);
        check_val("bufpri_row2", 64'(switch_config_buf[2]), 64'b0010);
        check_val("bufpri_pop",  64'(buf_pop), 64'b0010);
        check_val("bufpri_push", 64'(buf_push), 64'b0001);
        check_val("bufpri_cnt1", 64'(buf_count[1]), 64'd0);

        random_slots(300, 0);
        random_slots(300, 1);   // saturates buffers: drops and push-into-full-with-pop
        random_slots(5, 1);

        // Asynchronous reset between edges clears everything immediately.
        #2;
        rst_n = 1'b0;
        #1;
        check_val("arst_cfg",   64'(switch_config), 64'd0);
        check_val("arst_cfgb",  64'(switch_config_buf), 64'd0);
        check_val("arst_pulse", 64'({grant, buf_push, buf_pop, drop}), 64'd0);
        check_val("arst_count", 64'(buf_count), 64'd0);
        check_val("arst_dcnt",  64'(drop_cnt), 64'd0);
        @(negedge clk);
        do_reset();

        random_slots(100, 0);
        check_val("saw_drop", 64'(saw_drop), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
